tile_raster_engine: RTL and testbench

//  Parametrised tile renderer for the gameboard. Given a grid cell index and colours, emits one
//  VGA-adapter pixel write per cycle (x, y, color, plot), covering a TILE_W x TILE_H rectangle.

---
 rtl/tile_raster_engine.sv | 180 ++++++++++++++++++
 tb/tb_tile_raster_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_raster_engine.sv
// Tile raster engine: draws one grid tile as a stream of registered pixel writes,
// one per cycle, with optional 1-pixel outline and off-screen clipping.
module tile_raster_engine #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOR_W   = 3,
    parameter int TILE_W    = 19,
    parameter int TILE_H    = 14,
    parameter int GAP       = 1,
    parameter int ORIGIN_X  = 4,
    parameter int ORIGIN_Y  = 4,
    parameter int GRID_COLS = 8,
    parameter int GRID_ROWS = 8,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         tile_col,
    input  logic [3:0]         tile_row,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic [COLOR_W-1:0] border_color,
    input  logic               border_en,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               plot,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out
);

    localparam int PX_W = $clog2(TILE_W);
    localparam int PY_W = $clog2(TILE_H);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(TILE_H - 1);

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

    state_e             state_q, state_d;
    logic [PX_W-1:0]    px_q, px_d;
    logic [PY_W-1:0]    py_q, py_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         row_q, row_d;
    logic [COLOR_W-1:0] fill_q, fill_d;
    logic [COLOR_W-1:0] border_q, border_d;
    logic               ben_q, ben_d;
    logic               rej_q, rej_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;

    // Full-width pixel coordinates; kept wide so clipping sees the untruncated value
    logic [31:0] x_full, y_full;
    logic        on_edge;

    // Pixel coordinate and outline decode for the current raster position
    always_comb begin
        x_full  = 32'(ORIGIN_X) + 32'(col_q) * 32'(TILE_W + GAP) + 32'(px_q);
        y_full  = 32'(ORIGIN_Y) + 32'(row_q) * 32'(TILE_H + GAP) + 32'(py_q);
        on_edge = (px_q == '0) || (px_q == PX_LAST) || (py_q == '0) || (py_q == PY_LAST);
    end

    // Next-state logic: request capture, raster walk and registered pixel outputs
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        col_d    = col_q;
        row_d    = row_q;
        fill_d   = fill_q;
        border_d = border_q;
        ben_d    = ben_q;
        rej_d    = rej_q;
        busy_d   = (state_q != StIdle);
        done_d   = 1'b0;
        err_d    = 1'b0;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    col_d    = tile_col;
                    row_d    = tile_row;
                    fill_d   = fill_color;
                    border_d = border_color;
                    ben_d    = border_en;
                    px_d     = '0;
                    py_d     = '0;
                    if ((32'(tile_col) >= 32'(GRID_COLS)) || (32'(tile_row) >= 32'(GRID_ROWS))) begin
                        rej_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        rej_d   = 1'b0;
                        state_d = StDraw;
                    end
                end
            end
            StDraw: begin
                x_d     = x_full[X_W-1:0];
                y_d     = y_full[Y_W-1:0];
                color_d = (ben_q && on_edge) ? border_q : fill_q;
                // Clipped pixels still take a cycle so latency is geometry-independent
                plot_d  = (x_full < 32'(SCREEN_W)) && (y_full < 32'(SCREEN_H));
                if (px_q == PX_LAST) begin
                    px_d = '0;
                    if (py_q == PY_LAST) begin
                        state_d = StDone;
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                err_d   = rej_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            px_q     <= '0;
            py_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fill_q   <= '0;
            border_q <= '0;
            ben_q    <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            col_q    <= col_d;
            row_q    <= row_d;
            fill_q   <= fill_d;
            border_q <= border_d;
            ben_q    <= ben_d;
            rej_q    <= rej_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign plot      = plot_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign color_out = color_q;

endmodule

// File: tb/tb_tile_raster_engine.sv
// Directed bench for tile_raster_engine: default geometry instance plus a small-tile instance.
module tb_tile_raster_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] tile_col;
    logic [3:0] tile_row;
    logic [2:0] fill_color;
    logic [2:0] border_color;
    logic       border_en;

    logic       busy_a, done_a, err_a, plot_a;
    logic [7:0] x_a;
    logic [6:0] y_a;
    logic [2:0] c_a;
    logic       busy_b, done_b, err_b, plot_b;
    logic [7:0] x_b;
    logic [6:0] y_b;
    logic [2:0] c_b;

    always #5 clk = ~clk;

    tile_raster_engine u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tile_col     (tile_col),
        .tile_row     (tile_row),
        .fill_color   (fill_color),
        .border_color (border_color),
        .border_en    (border_en),
        .busy         (busy_a),
        .done         (done_a),
        .err          (err_a),
        .plot         (plot_a),
        .x_out        (x_a),
        .y_out        (y_a),
        .color_out    (c_a)
    );

    tile_raster_engine #(
        .TILE_W (4),
        .TILE_H (3),
        .GAP    (0)
    ) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tile_col     (tile_col),
        .tile_row     (tile_row),
        .fill_color   (fill_color),
        .border_color (border_color),
        .border_en    (border_en),
        .busy         (busy_b),
        .done         (done_b),
        .err          (err_b),
        .plot         (plot_b),
        .x_out        (x_b),
        .y_out        (y_b),
        .color_out    (c_b)
    );

    // Observed instance select
    logic       sel;
    logic       o_busy, o_done, o_err, o_plot;
    logic [7:0] o_x;
    logic [6:0] o_y;
    logic [2:0] o_c;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_err  = sel ? err_b  : err_a;
    assign o_plot = sel ? plot_b : plot_a;
    assign o_x    = sel ? x_b    : x_a;
    assign o_y    = sel ? y_b    : y_a;
    assign o_c    = sel ? c_b    : c_a;

    int total = 0;
    int bad   = 0;

    // Per-request statistics
    int n_plot, done_cyc, err_at_done, busy_bad;
    int fx, fy, lx, ly, xmin, xmax, ymin, ymax;
    int cnt_c [8];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input int col, input int row, input int fill, input int brd,
                         input bit ben);
        @(negedge clk);
        tile_col     = 4'(col);
        tile_row     = 4'(row);
        fill_color   = 3'(fill);
        border_color = 3'(brd);
        border_en    = ben;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Watch cycles 1..bound after acceptance until done appears
    task automatic collect(input int bound);
        n_plot = 0; done_cyc = -1; err_at_done = -1; busy_bad = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        xmin = 9999; xmax = -1; ymin = 9999; ymax = -1;
        for (int i = 0; i < 8; i++) cnt_c[i] = 0;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk);
            #1;
            if (!o_busy) busy_bad++;
            if (o_plot) begin
                if (n_plot == 0) begin
                    fx = int'(o_x);
                    fy = int'(o_y);
                end
                lx = int'(o_x);
                ly = int'(o_y);
                n_plot++;
                cnt_c[o_c]++;
                if (int'(o_x) < xmin) xmin = int'(o_x);
                if (int'(o_x) > xmax) xmax = int'(o_x);
                if (int'(o_y) < ymin) ymin = int'(o_y);
                if (int'(o_y) > ymax) ymax = int'(o_y);
            end
            if (o_done) begin
                done_cyc    = k;
                err_at_done = int'(o_err);
                break;
            end
        end
    endtask

    task automatic chk_idle_after(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, int'(o_done), 0);
        chk({tag, "_busy_drop"}, int'(o_busy), 0);
    endtask

    int col_bad, x_bad, ghost;

    initial begin
        sel = 1'b0;
        reset = 1'b1; start = 1'b0; tile_col = '0; tile_row = '0;
        fill_color = '0; border_color = '0; border_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_plot", int'(plot_a), 0);
        chk("rst_xyc", int'({x_a, y_a, c_a}), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: tile (0,0), plain fill
        issue(0, 0, 5, 7, 1'b0);
        collect(300);
        chk("t1_plots", n_plot, 266);
        chk("t1_first_x", fx, 4);
        chk("t1_first_y", fy, 4);
        chk("t1_last_x", lx, 22);
        chk("t1_last_y", ly, 17);
        chk("t1_col101", cnt_c[5], 266);
        chk("t1_done_cyc", done_cyc, 267);
        chk("t1_err", err_at_done, 0);
        chk("t1_busy_gaps", busy_bad, 0);
        chk_idle_after("t1");

        // 2: tile (1,2), outlined
        issue(1, 2, 1, 7, 1'b1);
        collect(300);
        chk("t2_xmin", xmin, 24);
        chk("t2_xmax", xmax, 42);
        chk("t2_ymin", ymin, 34);
        chk("t2_ymax", ymax, 47);
        chk("t2_outline", cnt_c[7], 62);
        chk("t2_interior", cnt_c[1], 204);
        chk("t2_done_cyc", done_cyc, 267);

        // 3: tile (7,7), partially off-screen
        issue(7, 7, 2, 7, 1'b0);
        collect(300);
        chk("t3_plots", n_plot, 176);
        chk("t3_xmin", xmin, 144);
        chk("t3_xmax", xmax, 159);
        chk("t3_ymin", ymin, 109);
        chk("t3_ymax", ymax, 119);
        chk("t3_done_cyc", done_cyc, 267);
        chk("t3_err", err_at_done, 0);

        // 4: column out of range is rejected
        issue(8, 0, 5, 7, 1'b0);
        collect(5);
        chk("t4_plots", n_plot, 0);
        chk("t4_done_cyc", done_cyc, 1);
        chk("t4_err", err_at_done, 1);
        chk("t4_busy", busy_bad, 0);
        @(posedge clk);
        #1;
        chk("t4_busy_drop", int'(o_busy), 0);
        chk("t4_err_drop", int'(o_err), 0);

        // 5: restart ignored mid-draw, then reset at pixel 100
        issue(0, 0, 5, 7, 1'b0);
        col_bad = 0; x_bad = 0; ghost = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (plot_a && c_a != 3'b101) col_bad++;
            if (plot_a && (x_a < 8'd4 || x_a > 8'd22)) x_bad++;
            if (done_a) ghost++;
            if (k == 50) begin
                start = 1'b1; fill_color = 3'b010; tile_col = 4'd3;
            end
            if (k == 51) start = 1'b0;
            if (k == 100) reset = 1'b1;
        end
        chk("t5_color_kept", col_bad, 0);
        chk("t5_tile_kept", x_bad, 0);
        @(posedge clk);
        #1;
        chk("t5_rst_outs", int'({busy_a, done_a, err_a, plot_a, x_a, y_a, c_a}), 0);
        reset = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (done_a || plot_a || busy_a) ghost++;
        end
        chk("t5_no_done", ghost, 0);
        issue(0, 0, 6, 7, 1'b0);
        collect(300);
        chk("t5_fresh_plots", n_plot, 266);
        chk("t5_fresh_col", cnt_c[6], 266);
        chk("t5_fresh_done", done_cyc, 267);
        chk_idle_after("t5");

        // 6: small-tile instance, tile (2,0)
        sel = 1'b1;
        issue(2, 0, 3, 7, 1'b0);
        collect(50);
        chk("t6_plots", n_plot, 12);
        chk("t6_xmin", xmin, 12);
        chk("t6_xmax", xmax, 15);
        chk("t6_ymin", ymin, 4);
        chk("t6_ymax", ymax, 6);
        chk("t6_done_cyc", done_cyc, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
